mmio_uart_tx: RTL and testbench

MMIO_UART_TX -- requirements
Module: mmio_uart_tx

---
 rtl/mmio_pkg.sv | 12 +
 rtl/mmio_uart_tx_if.sv | 11 +
 rtl/sync_fifo.sv | 49 ++++
 rtl/mmio_uart_tx.sv | 116 +++++++++++
 tb/tb_mmio_uart_tx.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/mmio_pkg.sv
// rtl/mmio_pkg.sv - shared address constants and transmitter state encoding
package mmio_pkg;
  localparam logic [31:0] DATA_ADDR_DEF = 32'hFFFF_0000;
  localparam logic [31:0] STAT_ADDR_DEF = 32'hFFFF_0004;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;
endpackage

// File: rtl/mmio_uart_tx_if.sv
// rtl/mmio_uart_tx_if.sv - CPU memory-mapped bus into the UART transmitter
interface mmio_uart_tx_if;
  logic        wr_en;
  logic [31:0] mem_addr;
  logic [31:0] w_data;
  logic        hit;
  logic [31:0] rd_data;

  modport master (output wr_en, mem_addr, w_data, input hit, rd_data);
  modport slave  (input wr_en, mem_addr, w_data, output hit, rd_data);
endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO; caller qualifies push/pop legality
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr_ptr] <= din;
  end

  // a separate count keeps full and empty distinct when the pointers coincide
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign dout  = r_mem[r_rd_ptr];
  assign count = r_count;
  assign full  = (r_count == CW'(DEPTH));
  assign empty = (r_count == '0);
endmodule

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped 8N1 UART transmitter with a byte FIFO
module mmio_uart_tx import mmio_pkg::*; #(
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [31:0] DATA_ADDR    = DATA_ADDR_DEF,
  parameter logic [31:0] STAT_ADDR    = STAT_ADDR_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clk_en,
  mmio_uart_tx_if.slave  bus,
  output logic           tx,
  output logic           busy
);
  localparam int CW  = $clog2(FIFO_DEPTH+1);
  localparam int CCW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  uart_state_e    r_state, w_state_nxt;
  logic [CCW-1:0] r_clk_cnt;
  logic [2:0]     r_bit_cnt;
  logic [7:0]     r_shift;
  logic           r_tx, r_ovf;
  logic           w_tx_nxt, w_shift_en, w_bit_end;
  logic           w_is_data, w_is_stat, w_push_try, w_push, w_pop;
  logic           w_ovf_set, w_ovf_clr;
  logic           w_full, w_empty;
  logic [7:0]     w_fifo_dout;
  logic [CW-1:0]  w_count;

  assign w_is_data  = (bus.mem_addr == DATA_ADDR);
  assign w_is_stat  = (bus.mem_addr == STAT_ADDR);
  assign w_bit_end  = (r_clk_cnt == CCW'(CLKS_PER_BIT-1));
  assign w_pop      = clk_en & ~w_empty &
                      ((r_state == IDLE) | ((r_state == STOP) & w_bit_end));
  assign w_push_try = clk_en & bus.wr_en & w_is_data;
  assign w_push     = w_push_try & (~w_full | w_pop);
  assign w_ovf_set  = w_push_try & w_full & ~w_pop;
  assign w_ovf_clr  = clk_en & bus.wr_en & w_is_stat & bus.w_data[2];

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (bus.w_data[7:0]),
    .dout  (w_fifo_dout),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  always_ff @(posedge clk) begin
    if (!rst)        r_state <= IDLE;
    else if (clk_en) r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:  if (!w_empty) w_state_nxt = START;
      START: if (w_bit_end) w_state_nxt = DATA;
      DATA:  if (w_bit_end && r_bit_cnt == 3'd7) w_state_nxt = STOP;
      STOP:  if (w_bit_end) w_state_nxt = w_empty ? IDLE : START;
      default: w_state_nxt = IDLE;
    endcase
  end

  // tx is registered, so this decides the line level for the coming bit period
  always_comb begin
    w_tx_nxt   = r_tx;
    w_shift_en = 1'b0;
    case (r_state)
      IDLE:  w_tx_nxt = w_empty;
      START: if (w_bit_end) begin
        w_tx_nxt   = r_shift[0];
        w_shift_en = 1'b1;
      end
      DATA:  if (w_bit_end) begin
        if (r_bit_cnt == 3'd7) begin
          w_tx_nxt = 1'b1;
        end else begin
          w_tx_nxt   = r_shift[0];
          w_shift_en = 1'b1;
        end
      end
      STOP:  if (w_bit_end) w_tx_nxt = w_empty;
      default: w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_tx      <= 1'b1;
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_ovf     <= 1'b0;
    end else if (clk_en) begin
      r_tx <= w_tx_nxt;
      if (w_pop)           r_shift <= w_fifo_dout;
      else if (w_shift_en) r_shift <= {1'b0, r_shift[7:1]};
      if (r_state == IDLE || w_bit_end) r_clk_cnt <= '0;
      else                              r_clk_cnt <= r_clk_cnt + CCW'(1);
      if (r_state != DATA) r_bit_cnt <= '0;
      else if (w_bit_end)  r_bit_cnt <= r_bit_cnt + 3'd1;
      if (w_ovf_set)      r_ovf <= 1'b1;
      else if (w_ovf_clr) r_ovf <= 1'b0;
    end
  end

  assign tx          = r_tx;
  assign busy        = (r_state != IDLE);
  assign bus.hit     = w_is_data | w_is_stat;
  assign bus.rd_data = w_is_stat ? {24'd0, 4'(w_count), busy, r_ovf, w_empty, ~w_full}
                                 : 32'd0;
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - vector table, directed frames and random traffic vs frame model
module tb_mmio_uart_tx;
  localparam int          CPB   = 4;
  localparam int          DEPTH = 4;
  localparam logic [31:0] DA    = 32'hFFFF_0000;
  localparam logic [31:0] SA    = 32'hFFFF_0004;
  localparam logic [31:0] OTHER = 32'hFFFF_0008;

  logic clk = 1'b0;
  logic rst, clk_en, tx, busy;
  mmio_uart_tx_if bus_if();

  mmio_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .DATA_ADDR(DA), .STAT_ADDR(SA)) dut (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .bus    (bus_if),
    .tx     (tx),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r, e, w;
    logic [31:0] a, d;
    logic        x_tx, x_busy, x_hit;
    logic [31:0] x_rd;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;

  // frame model: a byte queue plus the enabled-clock position inside the current frame
  logic [7:0] mq[$];
  bit         m_act;
  int         m_t;
  logic [7:0] m_cur;
  bit         m_ovf;

  function automatic logic m_tx();
    if (!m_act) return 1'b1;
    if (m_t < CPB) return 1'b0;
    if (m_t >= 9*CPB) return 1'b1;
    return m_cur[(m_t - CPB) / CPB];
  endfunction

  function automatic logic [31:0] m_status();
    return {24'd0, 4'(mq.size()), m_act, m_ovf, mq.size() == 0, mq.size() < DEPTH};
  endfunction

  task automatic model_edge(input logic r, e, w, input logic [31:0] a, d);
    bit frame_end, pop, dpush, ok;
    if (!r) begin
      mq.delete();
      m_act = 0; m_t = 0; m_ovf = 0;
    end else if (e) begin
      frame_end = m_act && (m_t == 10*CPB - 1);
      pop   = (mq.size() > 0) && (!m_act || frame_end);
      dpush = w && (a == DA);
      ok    = dpush && ((mq.size() < DEPTH) || pop);
      if (dpush && !ok) m_ovf = 1;
      else if (w && a == SA && d[2]) m_ovf = 0;
      if (pop) begin
        m_cur = mq.pop_front(); m_act = 1; m_t = 0;
      end else if (frame_end) m_act = 0;
      else if (m_act) m_t++;
      if (ok) mq.push_back(d[7:0]);
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, e, w, input logic [31:0] a, d);
    rst = r; clk_en = e; bus_if.wr_en = w; bus_if.mem_addr = a; bus_if.w_data = d;
    @(posedge clk);
    model_edge(r, e, w, a, d);
    #1;
  endtask

  task automatic apply(input logic r, e, w, input logic [31:0] a, d);
    drive(r, e, w, a, d);
    check("tx", tx, m_tx());
    check("busy", busy, m_act);
    check("hit", bus_if.hit, (a == DA) || (a == SA));
    check("rd_data", bus_if.rd_data, (a == SA) ? m_status() : 32'd0);
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) apply(1, 1, 0, SA, 0);
  endtask

  vec_t       tbl[8];
  logic       s[0:255];
  logic [9:0] fr;
  logic [7:0] byt, ref_byte;
  int         bcnt, errs;

  initial begin
    rst = 0; clk_en = 0; bus_if.wr_en = 0; bus_if.mem_addr = 0; bus_if.w_data = 0;
    tbl[0] = '{0, 0, 0, SA,    32'h0,  1, 0, 1, 32'h03};
    tbl[1] = '{1, 1, 0, OTHER, 32'h0,  1, 0, 0, 32'h00};
    tbl[2] = '{1, 1, 1, SA,    32'h4,  1, 0, 1, 32'h03};
    tbl[3] = '{1, 0, 1, DA,    32'hA5, 1, 0, 1, 32'h00};
    tbl[4] = '{1, 0, 0, SA,    32'h0,  1, 0, 1, 32'h03};
    tbl[5] = '{1, 1, 1, DA,    32'hA5, 1, 0, 1, 32'h00};
    tbl[6] = '{1, 0, 0, SA,    32'h0,  1, 0, 1, 32'h11};
    tbl[7] = '{1, 1, 0, SA,    32'h0,  0, 1, 1, 32'h0B};
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].r, tbl[i].e, tbl[i].w, tbl[i].a, tbl[i].d);
      check($sformatf("vec%0d_tx", i), tx, tbl[i].x_tx);
      check($sformatf("vec%0d_busy", i), busy, tbl[i].x_busy);
      check($sformatf("vec%0d_hit", i), bus_if.hit, tbl[i].x_hit);
      check($sformatf("vec%0d_rd", i), bus_if.rd_data, tbl[i].x_rd);
    end

    // rest of the 0xA5 frame, start bit already on the line
    fr = {1'b1, 8'hA5, 1'b0};
    for (int k = 1; k < 10*CPB; k++) begin
      apply(1, 1, 0, SA, 0);
      check("a5_bit", tx, fr[k / CPB]);
      check("a5_busy", busy, 1'b1);
    end
    apply(1, 1, 0, SA, 0);
    check("a5_end_busy", busy, 1'b0);
    check("a5_end_tx", tx, 1'b1);

    // five consecutive stores: the first byte leaves the FIFO on the second edge
    idle_n(3);
    apply(1, 1, 1, DA, 32'h41);
    bcnt = 0;
    for (int i = 1; i < 5; i++) begin
      apply(1, 1, 1, DA, 32'h41 + i);
      s[i-1] = tx; bcnt += int'(busy);
    end
    for (int i = 4; i < 5*10*CPB; i++) begin
      apply(1, 1, 0, SA, 0);
      s[i] = tx; bcnt += int'(busy);
    end
    check("b2b_ovf", bus_if.rd_data[2], 1'b0);
    check("b2b_busy_cycles", bcnt, 5*10*CPB);
    for (int i = 0; i < 5; i++) begin
      for (int b = 0; b < 8; b++) byt[b] = s[i*10*CPB + CPB*(b+1) + CPB/2];
      ref_byte = 8'h41 + 8'(i);
      check("b2b_byte", {24'd0, byt}, {24'd0, ref_byte});
      check("b2b_start", s[i*10*CPB + CPB/2], 1'b0);
    end
    apply(1, 1, 0, SA, 0);
    check("b2b_done", busy, 1'b0);

    // enable only on store edges: one byte in flight, four queued, the sixth dropped
    idle_n(2);
    for (int i = 0; i < 6; i++) begin
      apply(1, 1, 1, DA, 32'h41 + i);
      apply(1, 0, 0, SA, 0);
    end
    check("ovf_status", bus_if.rd_data, 32'h4C);
    apply(1, 1, 1, SA, 32'h4);
    apply(1, 0, 0, SA, 0);
    check("ovf_cleared", bus_if.rd_data, 32'h48);
    idle_n(6*10*CPB);

    // clk_en toggling during 0x5A: every bit doubles to 2*CPB clocks
    apply(1, 1, 1, DA, 32'h5A);
    for (int j = 0; j < 20*CPB; j++) begin
      apply(1, (j % 2) == 0, 0, SA, 0);
      s[j] = tx;
    end
    fr = {1'b1, 8'h5A, 1'b0};
    for (int b = 0; b < 10; b++) begin
      errs = 0;
      for (int j = 0; j < 2*CPB; j++) if (s[b*2*CPB + j] !== fr[b]) errs++;
      check("toggle_bit_width", errs, 0);
    end
    idle_n(4);

    // reset in the middle of bit 3 with a second byte queued
    apply(1, 1, 1, DA, 32'h33);
    apply(1, 1, 1, DA, 32'h77);
    idle_n(3*CPB);
    check("pre_rst_bit3", tx, 1'b0);
    check("pre_rst_busy", busy, 1'b1);
    apply(0, 1, 0, SA, 0);
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    apply(1, 1, 0, SA, 0);
    check("rst_status", bus_if.rd_data, 32'h03);

    // random traffic against the frame model
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] a;
      int sel;
      sel = $urandom_range(0, 9);
      a = (sel < 6) ? DA : (sel < 8) ? SA : (sel == 8 ? OTHER : 32'h1234_5678);
      apply($urandom_range(0, 299) != 0, ($urandom % 4) != 0, ($urandom % 3) == 0, a, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
